spi_bus_bridge: RTL and testbench
=================================

Name: spi_bus_bridge

Overview:
- Byte-stream command engine between the spi_trx byte interface and a generic parametrised register/memory bus.
- Successor to the fixed-format CSR/PROM/DRAM SPI decoder.
- Adds configurable address and data widths, up to 16 targets, explicit 1..256 word bursts, optional auto-increment, a bus timeout, a busy/retry reply and a sticky error status.
- Sits between spi_trx and the target mux for csr, nkmd prom and dram peek/poke.

Parameters:
- ADDR_BYTES, 4, address bytes per command (1..4); bus_addr width AW = 8*ADDR_BYTES.
- DATA_BYTES, 4, bytes per bus word (1..4); DW = 8*DATA_BYTES.
- NUM_TARGET, 4, number of bus targets (1..16); TW = max(1, clog2(NUM_TARGET)).
- TIMEOUT, 1024, cycles bus_req may wait for bus_ack before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- frame_rst  in  1  spi_trx rst_o; ss deasserted, end of frame.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse: rx_data valid.
- tx_data  out  8  reply byte.
- tx_valid  out  1  one-cycle pulse: tx_data valid.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  1 = write.
- bus_tgt  out  TW  target index.
- bus_addr  out  AW  word address.
- bus_wdata  out  DW  write data.
- bus_rdata  in  DW  read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion pulse.
- err_o  out  1  sticky error.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal counters 0.
- Every rx_valid produces exactly one tx_valid pulse on the next cycle (latency 1), with the reply byte on tx_data.
- Frame format: CMD, LEN, ADDR[ADDR_BYTES] MSB first, then (LEN+1) words of DATA_BYTES bytes each, MSB first.
- CMD fields: [7] we, [6] incr, [5:4] kind (00 access, 11 status, other = error), [3:0] target.
- A target index >= NUM_TARGET is an error.
- States:
  - IDLE: on CMD, latch fields. Access → LEN, reply 0xA0. Status → IDLE, reply {0x5, 3'b0, err}, then clear err. Error → DRAIN, reply 0xE1, set err.
  - LEN: latch count = LEN; reply 0xA1; → ADDR.
  - ADDR: shift in byte, reply 0xA2. After the last address byte: → WDATA if we=1, else → RREQ.
  - WDATA: shift byte into wdata, reply {0xD, 2'b0, idx[1:0]}. After the last byte → WREQ.
  - WREQ/RREQ: bus_req=1 and bus_we=we from entry until the cycle bus_ack is sampled; req drops the following cycle.
  - On ack in WREQ: if count==0 → IDLE, else count-1, addr update, → WDATA.
  - On ack in RREQ: latch bus_rdata, idx=0, → RDATA.
  - RDATA: each rx byte (content ignored) replies rdata byte idx, MSB first. After the last byte: if count==0 → IDLE, else count-1, addr update, → RREQ.
  - DRAIN: reply 0xEE to every byte until frame_rst.
- Address update: addr+1 modulo 2^AW when incr=1; unchanged when incr=0 (FIFO-style port).
- rx_valid during RREQ: reply 0xEB, byte discarded, no error. The host retries (poll semantics).
- rx_valid during WREQ: reply 0xEB, byte discarded, set err (write overrun), stay in WREQ.
- Timeout: the counter starts at entry to WREQ/RREQ. If bus_ack has not arrived after TIMEOUT cycles: drop bus_req, set err, → DRAIN.
- bus_ack arriving while not requesting is ignored.
- frame_rst in WREQ/RREQ: finish the handshake (ack or timeout), then → IDLE.
  - frame_rst in any other state → IDLE the next cycle.
  - A pending tx_valid still pulses.
- rx_valid and frame_rst in the same cycle: frame_rst wins and the byte is discarded.
- err is cleared only by rst or a status command. A status command has priority over a simultaneous set.

Decomposition:
- Package spi_bus_pkg holds:
  - Reply-code constants: 0xA0, 0xA1, 0xA2, 0xD0, 0x50, 0xE1, 0xEB, 0xEE.
  - CMD field bit positions and kind encodings.
  - A state enum.
- Sub-module spi_bus_cmd_decoder: combinational CMD byte → we, incr, kind, target, target_valid.

Test Plan:
- Write, incr=1, tgt 2, LEN 1, addr 0x00000010, data 0x11223344 and 0x55667788 with ack 3 cycles after req:
  - Bus sees write 0x11223344@0x10, then 0x55667788@0x11.
  - Replies A0 A1 A2 A2 A2 A2 D0 D1 D2 D3 D0 D1 D2 D3.
- Read, incr=0, LEN 0, addr 0x20, rdata 0xCAFEBABE, host sends 1 byte early:
  - Early byte replies EB.
  - Next four bytes reply CA FE BA BE.
  - Exactly one bus_req issued.
- Address wrap with ADDR_BYTES=1: incr read LEN 2 at 0xFF → addresses 0xFF, 0x00, 0x01.
- Timeout: no ack for TIMEOUT cycles → bus_req low at cycle TIMEOUT+1, err_o=1, subsequent bytes reply EE; status cmd 0x30 after frame_rst → reply 0x51, then err_o=0.
- Bad target 0x0F with NUM_TARGET=4 → reply E1, no bus_req, err set; write overrun byte during WREQ → reply EB, err set.
- frame_rst mid-ADDR → next CMD decoded from IDLE; frame_rst during RREQ → req held until ack, then IDLE.

Source files
------------

// File: rtl/spi_bus_pkg.sv
// Shared reply codes, CMD byte layout and FSM states for the SPI command bridge.
package spi_bus_pkg;

  localparam logic [7:0] RPL_CMD    = 8'hA0;
  localparam logic [7:0] RPL_LEN    = 8'hA1;
  localparam logic [7:0] RPL_ADDR   = 8'hA2;
  localparam logic [7:0] RPL_WDATA  = 8'hD0;
  localparam logic [7:0] RPL_STATUS = 8'h50;
  localparam logic [7:0] RPL_BADCMD = 8'hE1;
  localparam logic [7:0] RPL_BUSY   = 8'hEB;
  localparam logic [7:0] RPL_DRAIN  = 8'hEE;

  localparam int CMD_WE_BIT   = 7;
  localparam int CMD_INCR_BIT = 6;
  localparam int CMD_KIND_LSB = 4;
  localparam int CMD_TGT_LSB  = 0;

  typedef enum logic [1:0] {
    KIND_ACCESS = 2'b00,
    KIND_RSVD_A = 2'b01,
    KIND_RSVD_B = 2'b10,
    KIND_STATUS = 2'b11
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR,
    ST_WDATA,
    ST_WREQ,
    ST_RREQ,
    ST_RDATA,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/spi_bus_cmd_decoder.sv
// Splits a CMD byte into its fields and flags targets outside the populated range.
module spi_bus_cmd_decoder
  import spi_bus_pkg::*;
#(
  parameter int NUM_TARGET = 4,
  parameter int TW         = 2
) (
  input  logic [7:0]    cmd,
  output logic          we,
  output logic          incr,
  output cmd_kind_e     kind,
  output logic [TW-1:0] target,
  output logic          target_valid
);

  logic [3:0] tgt_full;

  assign tgt_full     = cmd[CMD_TGT_LSB +: 4];
  assign we           = cmd[CMD_WE_BIT];
  assign incr         = cmd[CMD_INCR_BIT];
  assign kind         = cmd_kind_e'(cmd[CMD_KIND_LSB +: 2]);
  assign target       = tgt_full[TW-1:0];
  assign target_valid = ({28'd0, tgt_full} < 32'(NUM_TARGET));

endmodule

// File: rtl/spi_bus_bridge.sv
// Byte-stream command engine: turns spi_trx bytes into bursts on a generic
// register/memory bus and streams one reply byte back for every byte received.
module spi_bus_bridge
  import spi_bus_pkg::*;
#(
  parameter  int ADDR_BYTES = 4,
  parameter  int DATA_BYTES = 4,
  parameter  int NUM_TARGET = 4,
  parameter  int TIMEOUT    = 1024,
  localparam int AW         = 8 * ADDR_BYTES,
  localparam int DW         = 8 * DATA_BYTES,
  localparam int TW         = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  output logic          bus_req,
  output logic          bus_we,
  output logic [TW-1:0] bus_tgt,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          err_o,
  output logic          busy_o
);

  localparam int TMW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            we_q, we_d, incr_q, incr_d, abort_q, abort_d, err_q, err_d;
  logic [TW-1:0]   tgt_q, tgt_d;
  logic [7:0]      count_q, count_d;
  logic [1:0]      idx_q, idx_d;
  logic [AW-1:0]   addr_q, addr_d, addr_next;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TMW-1:0]  tmo_q, tmo_d;
  logic [7:0]      tx_data_d;
  logic            tx_valid_d, err_set, err_clr, in_req;

  logic            dec_we, dec_incr, dec_tgt_valid;
  cmd_kind_e       dec_kind;
  logic [TW-1:0]   dec_tgt;

  spi_bus_cmd_decoder #(.NUM_TARGET(NUM_TARGET), .TW(TW)) u_dec (
    .cmd          (rx_data),
    .we           (dec_we),
    .incr         (dec_incr),
    .kind         (dec_kind),
    .target       (dec_tgt),
    .target_valid (dec_tgt_valid)
  );

  assign in_req    = (state_q == ST_WREQ) || (state_q == ST_RREQ);
  assign addr_next = incr_q ? addr_q + AW'(1) : addr_q;

  assign bus_req   = in_req;
  assign bus_we    = in_req & we_q;
  assign bus_tgt   = tgt_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign err_o     = err_q;
  assign busy_o    = (state_q != ST_IDLE);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    incr_d     = incr_q;
    abort_d    = abort_q;
    tgt_d      = tgt_q;
    count_d    = count_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tmo_d      = '0;
    tx_data_d  = tx_data;
    tx_valid_d = rx_valid;
    err_set    = 1'b0;
    err_clr    = 1'b0;

    if (frame_rst && !in_req) begin
      // End of frame outside a bus handshake: any byte in this cycle is dropped.
      state_d = ST_IDLE;
      idx_d   = '0;
      if (rx_valid) tx_data_d = RPL_DRAIN;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          we_d   = dec_we;
          incr_d = dec_incr;
          tgt_d  = dec_tgt;
          idx_d  = '0;
          if (dec_kind == KIND_ACCESS && dec_tgt_valid) begin
            state_d   = ST_LEN;
            tx_data_d = RPL_CMD;
          end else if (dec_kind == KIND_STATUS) begin
            tx_data_d = RPL_STATUS | 8'(err_q);
            err_clr   = 1'b1;
          end else begin
            state_d   = ST_DRAIN;
            tx_data_d = RPL_BADCMD;
            err_set   = 1'b1;
          end
        end

        ST_LEN: if (rx_valid) begin
          count_d   = rx_data;
          tx_data_d = RPL_LEN;
          state_d   = ST_ADDR;
        end

        ST_ADDR: if (rx_valid) begin
          addr_d    = AW'({addr_q, rx_data});
          tx_data_d = RPL_ADDR;
          if (idx_q == 2'(ADDR_BYTES - 1)) begin
            idx_d   = '0;
            state_d = we_q ? ST_WDATA : ST_RREQ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end

        ST_WDATA: if (rx_valid) begin
          wdata_d   = DW'({wdata_q, rx_data});
          tx_data_d = RPL_WDATA | 8'(idx_q);
          if (idx_q == 2'(DATA_BYTES - 1)) begin
            idx_d   = '0;
            state_d = ST_WREQ;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end

        ST_WREQ, ST_RREQ: begin
          // A frame end cannot abandon the bus mid-handshake; remember it instead.
          if (frame_rst) abort_d = 1'b1;
          if (rx_valid) begin
            tx_data_d = frame_rst ? RPL_DRAIN : RPL_BUSY;
            if (!frame_rst && state_q == ST_WREQ) err_set = 1'b1;
          end
          if (bus_ack) begin
            abort_d = 1'b0;
            idx_d   = '0;
            if (abort_q || frame_rst) begin
              state_d = ST_IDLE;
            end else if (state_q == ST_RREQ) begin
              rdata_d = bus_rdata;
              state_d = ST_RDATA;
            end else if (count_q == 8'd0) begin
              state_d = ST_IDLE;
            end else begin
              count_d = count_q - 8'd1;
              addr_d  = addr_next;
              state_d = ST_WDATA;
            end
          end else if (tmo_q == TMW'(TIMEOUT - 1)) begin
            abort_d = 1'b0;
            err_set = 1'b1;
            state_d = (abort_q || frame_rst) ? ST_IDLE : ST_DRAIN;
          end else begin
            tmo_d = tmo_q + TMW'(1);
          end
        end

        ST_RDATA: if (rx_valid) begin
          tx_data_d = rdata_q[DW-1 -: 8];
          rdata_d   = rdata_q << 8;
          if (idx_q == 2'(DATA_BYTES - 1)) begin
            idx_d = '0;
            if (count_q == 8'd0) begin
              state_d = ST_IDLE;
            end else begin
              count_d = count_q - 8'd1;
              addr_d  = addr_next;
              state_d = ST_RREQ;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end

        ST_DRAIN: if (rx_valid) tx_data_d = RPL_DRAIN;

        default: state_d = ST_IDLE;
      endcase
    end

    // A status read clears err even if something tried to set it the same cycle.
    err_d = err_clr ? 1'b0 : (err_set ? 1'b1 : err_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      incr_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      tgt_q    <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      tmo_q    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      incr_q   <= incr_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      tgt_q    <= tgt_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench for spi_bus_bridge: a default-geometry instance (a_*) and a
// one-address-byte instance (b_*) used for the address wrap sequence.
module tb_spi_bus_bridge;

  localparam int TIMEOUT = 1024;

  typedef struct packed {
    logic       wait_bus;
    logic [7:0] rx;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  tgt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_frame_rst = 1'b0, a_rx_valid = 1'b0, a_ack = 1'b0;
  logic [7:0]  a_rx_data = 8'h00, a_tx_data;
  logic        a_tx_valid, a_req, a_we, a_err, a_busy;
  logic [1:0]  a_tgt;
  logic [31:0] a_addr, a_wdata, a_rdata = 32'h0;

  logic        b_frame_rst = 1'b0, b_rx_valid = 1'b0, b_ack = 1'b0;
  logic [7:0]  b_rx_data = 8'h00, b_tx_data;
  logic        b_tx_valid, b_req, b_we, b_err, b_busy;
  logic [1:0]  b_tgt;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata, b_rdata = 32'h0;

  spi_bus_bridge #(.ADDR_BYTES(4), .DATA_BYTES(4), .NUM_TARGET(4), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .frame_rst(a_frame_rst), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .bus_req(a_req), .bus_we(a_we), .bus_tgt(a_tgt),
    .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_rdata(a_rdata), .bus_ack(a_ack),
    .err_o(a_err), .busy_o(a_busy)
  );

  spi_bus_bridge #(.ADDR_BYTES(1), .DATA_BYTES(4), .NUM_TARGET(4), .TIMEOUT(TIMEOUT)) u_dut8 (
    .clk(clk), .rst(rst), .frame_rst(b_frame_rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .bus_req(b_req), .bus_we(b_we), .bus_tgt(b_tgt),
    .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_rdata(b_rdata), .bus_ack(b_ack),
    .err_o(b_err), .busy_o(b_busy)
  );

  // Bus slave models: ack a_delay/b_delay cycles after req, logging each completed access.
  int   a_delay = 3, b_delay = 3, a_wait = 0, b_wait = 0, a_req_cnt = 0;
  bit   a_ack_en = 1'b1, a_req_prev = 1'b0;
  txn_t a_log[$];
  txn_t b_log[$];

  always @(negedge clk) begin
    if (a_req && !a_req_prev) a_req_cnt++;
    a_req_prev = a_req;
    if (a_ack) begin
      a_ack  = 1'b0;
      a_wait = 0;
    end else if (a_req && a_ack_en) begin
      a_wait++;
      if (a_wait >= a_delay) begin
        a_ack = 1'b1;
        a_log.push_back('{we: a_we, tgt: 4'(a_tgt), addr: a_addr, wdata: a_wdata});
      end
    end else begin
      a_wait = 0;
    end
  end

  always @(negedge clk) begin
    if (b_ack) begin
      b_ack  = 1'b0;
      b_wait = 0;
    end else if (b_req) begin
      b_wait++;
      if (b_wait >= b_delay) begin
        b_ack   = 1'b1;
        b_rdata = 32'hA500_0000 | {24'd0, b_addr};
        b_log.push_back('{we: b_we, tgt: 4'(b_tgt), addr: {24'd0, b_addr}, wdata: b_wdata});
      end
    end else begin
      b_wait = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic [7:0] exp, input string name);
    @(negedge clk);
    if (sel) begin b_rx_data = b; b_rx_valid = 1'b1; end
    else     begin a_rx_data = b; a_rx_valid = 1'b1; end
    @(posedge clk); #1;
    a_rx_valid = 1'b0;
    b_rx_valid = 1'b0;
    check({name, "_valid"}, 32'(sel ? b_tx_valid : a_tx_valid), 32'd1);
    check(name, 32'(sel ? b_tx_data : a_tx_data), 32'(exp));
  endtask

  task automatic pulse_frame_rst(input bit sel);
    @(negedge clk);
    if (sel) b_frame_rst = 1'b1; else a_frame_rst = 1'b1;
    @(posedge clk); #1;
    a_frame_rst = 1'b0;
    b_frame_rst = 1'b0;
  endtask

  task automatic wait_bus_idle(input bit sel, input string name);
    int n = 0;
    while ((sel ? b_req : a_req) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(sel ? b_req : a_req), 32'd0);
  endtask

  vec_t vecs[$];

  task automatic add(input logic w, input logic [7:0] rx, input logic [7:0] exp);
    vecs.push_back('{wait_bus: w, rx: rx, exp: exp});
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      if (vecs[i].wait_bus) wait_bus_idle(1'b0, $sformatf("%s_wait%0d", tag, i));
      send(1'b0, vecs[i].rx, vecs[i].exp, $sformatf("%s_b%0d", tag, i));
    end
    vecs.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_req, base_log, hc;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(a_tx_valid), 32'd0);
    check("rst_tx_data",  32'(a_tx_data),  32'd0);
    check("rst_bus_req",  32'(a_req),      32'd0);
    check("rst_err",      32'(a_err),      32'd0);
    check("rst_busy",     32'(a_busy),     32'd0);
    check("rst_addr",     a_addr,          32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write burst: incr, tgt 2, two words starting at 0x10.
    add(0, 8'hC2, 8'hA0); add(0, 8'h01, 8'hA1);
    add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h10, 8'hA2);
    add(0, 8'h11, 8'hD0); add(0, 8'h22, 8'hD1); add(0, 8'h33, 8'hD2); add(0, 8'h44, 8'hD3);
    add(1, 8'h55, 8'hD0); add(0, 8'h66, 8'hD1); add(0, 8'h77, 8'hD2); add(0, 8'h88, 8'hD3);
    run_vecs("wr");
    wait_bus_idle(1'b0, "wr_done");
    check("wr_busy",   32'(a_busy), 32'd0);
    check("wr_err",    32'(a_err),  32'd0);
    check("wr_ntxn",   32'(a_log.size()), 32'd2);
    if (a_log.size() == 2) begin
      check("wr0_we",   32'(a_log[0].we),  32'd1);
      check("wr0_tgt",  32'(a_log[0].tgt), 32'd2);
      check("wr0_addr", a_log[0].addr,     32'h10);
      check("wr0_data", a_log[0].wdata,    32'h1122_3344);
      check("wr1_addr", a_log[1].addr,     32'h11);
      check("wr1_data", a_log[1].wdata,    32'h5566_7788);
    end

    // Single-word non-incrementing read from 0x20 with one early poll byte.
    base_req = a_req_cnt;
    base_log = a_log.size();
    a_rdata  = 32'hCAFE_BABE;
    add(0, 8'h01, 8'hA0); add(0, 8'h00, 8'hA1);
    add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h20, 8'hA2);
    add(0, 8'h00, 8'hEB);
    add(1, 8'h00, 8'hCA); add(0, 8'h00, 8'hFE); add(0, 8'h00, 8'hBA); add(0, 8'h00, 8'hBE);
    run_vecs("rd");
    check("rd_nreq", 32'(a_req_cnt - base_req), 32'd1);
    check("rd_busy", 32'(a_busy), 32'd0);
    check("rd_err",  32'(a_err),  32'd0);
    if (a_log.size() == base_log + 1) begin
      check("rd_addr", a_log[base_log].addr,     32'h20);
      check("rd_we",   32'(a_log[base_log].we),  32'd0);
      check("rd_tgt",  32'(a_log[base_log].tgt), 32'd1);
    end else begin
      check("rd_ntxn", 32'(a_log.size() - base_log), 32'd1);
    end

    // Address wrap on the one-byte-address instance: 0xFF, 0x00, 0x01.
    send(1'b1, 8'h40, 8'hA0, "wrap_cmd");
    send(1'b1, 8'h02, 8'hA1, "wrap_len");
    send(1'b1, 8'hFF, 8'hA2, "wrap_addr");
    for (int w = 0; w < 3; w++) begin
      logic [7:0] ea;
      ea = 8'hFF + 8'(w);
      wait_bus_idle(1'b1, $sformatf("wrap_wait%0d", w));
      send(1'b1, 8'h00, 8'hA5, $sformatf("wrap%0d_b0", w));
      send(1'b1, 8'h00, 8'h00, $sformatf("wrap%0d_b1", w));
      send(1'b1, 8'h00, 8'h00, $sformatf("wrap%0d_b2", w));
      send(1'b1, 8'h00, ea,    $sformatf("wrap%0d_b3", w));
    end
    check("wrap_busy", 32'(b_busy), 32'd0);
    check("wrap_ntxn", 32'(b_log.size()), 32'd3);
    if (b_log.size() == 3) begin
      check("wrap_a0", b_log[0].addr, 32'hFF);
      check("wrap_a1", b_log[1].addr, 32'h00);
      check("wrap_a2", b_log[2].addr, 32'h01);
    end

    // Bad target: error reply, drain, no bus cycle; status read reports and clears err.
    base_req = a_req_cnt;
    send(1'b0, 8'h0F, 8'hE1, "badtgt_cmd");
    check("badtgt_err",  32'(a_err),  32'd1);
    send(1'b0, 8'h12, 8'hEE, "badtgt_drain");
    check("badtgt_nreq", 32'(a_req_cnt - base_req), 32'd0);
    pulse_frame_rst(1'b0);
    check("badtgt_idle", 32'(a_busy), 32'd0);
    send(1'b0, 8'h30, 8'h51, "status_set");
    check("status_clr_err", 32'(a_err), 32'd0);
    send(1'b0, 8'h30, 8'h50, "status_clear");

    // Write overrun: a byte during WREQ is refused and flags err.
    a_delay = 4;
    add(0, 8'h80, 8'hA0); add(0, 8'h00, 8'hA1);
    add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h40, 8'hA2);
    add(0, 8'hDE, 8'hD0); add(0, 8'hAD, 8'hD1); add(0, 8'hBE, 8'hD2); add(0, 8'hEF, 8'hD3);
    add(0, 8'h99, 8'hEB);
    add(1, 8'h30, 8'h51); add(0, 8'h30, 8'h50);
    run_vecs("ovr");
    a_delay = 3;

    // Timeout: no ack ever, req must stay high exactly TIMEOUT cycles.
    a_ack_en = 1'b0;
    add(0, 8'h00, 8'hA0); add(0, 8'h00, 8'hA1);
    add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h00, 8'hA2); add(0, 8'h30, 8'hA2);
    run_vecs("tmo");
    hc = 0;
    for (int g = 0; g < 2 * TIMEOUT; g++) begin
      if (!a_req) break;
      hc++;
      @(posedge clk); #1;
    end
    check("tmo_req_cycles", 32'(hc), 32'(TIMEOUT));
    check("tmo_err",  32'(a_err),  32'd1);
    check("tmo_busy", 32'(a_busy), 32'd1);
    send(1'b0, 8'h55, 8'hEE, "tmo_drain");
    pulse_frame_rst(1'b0);
    send(1'b0, 8'h30, 8'h51, "tmo_status");
    check("tmo_err_clr", 32'(a_err), 32'd0);
    a_ack_en = 1'b1;

    // frame_rst mid-ADDR: next byte is decoded as a fresh CMD.
    send(1'b0, 8'h01, 8'hA0, "fa_cmd");
    send(1'b0, 8'h00, 8'hA1, "fa_len");
    send(1'b0, 8'h00, 8'hA2, "fa_a0");
    send(1'b0, 8'h00, 8'hA2, "fa_a1");
    pulse_frame_rst(1'b0);
    check("fa_idle", 32'(a_busy), 32'd0);
    send(1'b0, 8'h30, 8'h50, "fa_status");

    // frame_rst during RREQ of a two-word read: handshake completes, then IDLE.
    a_delay  = 6;
    base_req = a_req_cnt;
    send(1'b0, 8'h00, 8'hA0, "fr_cmd");
    send(1'b0, 8'h01, 8'hA1, "fr_len");
    send(1'b0, 8'h00, 8'hA2, "fr_a0");
    send(1'b0, 8'h00, 8'hA2, "fr_a1");
    send(1'b0, 8'h00, 8'hA2, "fr_a2");
    send(1'b0, 8'h50, 8'hA2, "fr_a3");
    pulse_frame_rst(1'b0);
    check("fr_req_held", 32'(a_req), 32'd1);
    wait_bus_idle(1'b0, "fr_done");
    check("fr_busy", 32'(a_busy), 32'd0);
    check("fr_nreq", 32'(a_req_cnt - base_req), 32'd1);
    check("fr_err",  32'(a_err), 32'd0);
    a_delay = 3;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
